// File: rtl/mpu6050_i2c_responder.sv
// mpu6050_i2c_responder: I2C target emulating an MPU6050 register map with port-fed accel samples.
module mpu6050_i2c_responder #(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter logic [7:0] PWR_MGMT_RST = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] accel_x,
  input  logic [15:0] accel_y,
  input  logic [15:0] accel_z,
  output logic [7:0]  pwr_mgmt_1,
  output logic [7:0]  smplrt_div,
  output logic        wr_strobe,
  output logic        busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE
  } state_t;
  state_t state_q, state_d;
  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, ptr_q, ptr_d, pwr_q, pwr_d, smp_q, smp_d;
  logic [47:0] snap_q, snap_d;
  logic oe_q, oe_d, strb_q, strb_d, busy_q, busy_d;
  logic scl, sda, scl_rise, scl_fall, start, stop, byte_done, match;
  logic [7:0] rd_ptr, rd_byte;
  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl & ~scl_prev_q;
  assign scl_fall  = ~scl & scl_prev_q;
  assign start     = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop      = scl & scl_prev_q & ~sda_prev_q & sda;
  assign byte_done = cnt_q == 4'd8;
  assign match     = sh_q[7:1] == DEV_ADDR;
  assign rd_ptr    = (state_q == MACK) ? ptr_q + 8'd1 : ptr_q;
  assign sda_oe     = oe_q;
  assign pwr_mgmt_1 = pwr_q;
  assign smplrt_div = smp_q;
  assign wr_strobe  = strb_q;
  assign busy       = busy_q;
  // Burst reads of 0x3B..0x40 come from the snapshot so the six bytes are coherent
  always_comb begin
    rd_byte = 8'h00;
    case (rd_ptr)
      8'h3B: rd_byte = snap_q[47:40];
      8'h3C: rd_byte = snap_q[39:32];
      8'h3D: rd_byte = snap_q[31:24];
      8'h3E: rd_byte = snap_q[23:16];
      8'h3F: rd_byte = snap_q[15:8];
      8'h40: rd_byte = snap_q[7:0];
      8'h75: rd_byte = WHO_AM_I_VAL;
      8'h6B: rd_byte = pwr_q;
      8'h19: rd_byte = smp_q;
      default: rd_byte = 8'h00;
    endcase
  end
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl;
    sda_prev_d = sda;
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    ptr_d      = ptr_q;
    pwr_d      = pwr_q;
    smp_d      = smp_q;
    snap_d     = snap_q;
    oe_d       = oe_q;
    strb_d     = 1'b0;
    busy_d     = busy_q;
    if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda};
            cnt_d = cnt_q + 4'd1;
          end
          if (scl_fall && byte_done) begin
            cnt_d   = '0;
            oe_d    = match;
            busy_d  = match;
            state_d = match ? ADDR_ACK : IGNORE;
            if (match && sh_q[0]) snap_d = {accel_x, accel_y, accel_z};
          end
        end
        ADDR_ACK: if (scl_fall) begin
          state_d = sh_q[0] ? RDATA : REG;
          sh_d    = sh_q[0] ? rd_byte : sh_q;
          oe_d    = sh_q[0] & ~rd_byte[7];
          cnt_d   = '0;
        end
        REG: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda};
            cnt_d = cnt_q + 4'd1;
          end
          if (scl_fall && byte_done) begin
            ptr_d   = sh_q;
            cnt_d   = '0;
            oe_d    = 1'b1;
            state_d = REG_ACK;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda};
            cnt_d = cnt_q + 4'd1;
          end
          if (scl_fall && byte_done) begin
            pwr_d   = (ptr_q == 8'h6B) ? sh_q : pwr_q;
            smp_d   = (ptr_q == 8'h19) ? sh_q : smp_q;
            ptr_d   = ptr_q + 8'd1;
            strb_d  = 1'b1;
            cnt_d   = '0;
            oe_d    = 1'b1;
            state_d = WDATA_ACK;
          end
        end
        REG_ACK, WDATA_ACK: if (scl_fall) begin
          oe_d    = 1'b0;
          state_d = WDATA;
        end
        RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            state_d = byte_done ? MACK : RDATA;
            cnt_d   = byte_done ? 4'd0 : cnt_q;
            oe_d    = byte_done ? 1'b0 : ~sh_q[6];
            sh_d    = {sh_q[6:0], 1'b0};
          end
        end
        MACK: begin
          if (scl_rise && sda) state_d = IGNORE;
          if (scl_fall) begin
            ptr_d   = rd_ptr;
            sh_d    = rd_byte;
            oe_d    = ~rd_byte[7];
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
        default: oe_d = 1'b0;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      ptr_q      <= '0;
      pwr_q      <= PWR_MGMT_RST;
      smp_q      <= '0;
      snap_q     <= '0;
      oe_q       <= 1'b0;
      strb_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      pwr_q      <= pwr_d;
      smp_q      <= smp_d;
      snap_q     <= snap_d;
      oe_q       <= oe_d;
      strb_q     <= strb_d;
      busy_q     <= busy_d;
    end
  end
endmodule
